serial_frame_rx: RTL and testbench



---
 rtl/serial_frame_rx_if.sv | 27 ++
 rtl/serial_frame_rx.sv | 151 +++++++++++++++
 tb/tb_serial_frame_rx.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/serial_frame_rx_if.sv
// Bus bundle for serial_frame_rx: serial bit input, parallel word output and status pulses.
// Handshake: a word transfers on any clk edge where data_valid=1 and data_ready=1; data_out is held stable
// while data_valid=1 and not yet taken, and data_ready is ignored while data_valid=0.
interface serial_frame_rx_if #(
  parameter int DATA_W = 8
);
  logic              bit_en;
  logic              serial_in;
  logic              data_ready;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              busy;
  logic              frame_err;
  logic              parity_err;
  logic              overrun;
  logic [1:0]        state_dbg;

  modport master (
    output bit_en, serial_in, data_ready,
    input  data_out, data_valid, busy, frame_err, parity_err, overrun, state_dbg
  );

  modport slave (
    input  bit_en, serial_in, data_ready,
    output data_out, data_valid, busy, frame_err, parity_err, overrun, state_dbg
  );
endinterface

// File: rtl/serial_frame_rx.sv
// Framed serial receiver: start 0, DATA_W data bits, optional even parity, stop 1, valid/ready output.
// Define SERIAL_FRAME_RX_PARITY_EN to insert the parity bit and enable parity_err.
module serial_frame_rx #(
  parameter int DATA_W    = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input logic              clk,
  input logic              rst,
  serial_frame_rx_if.slave bus
);
  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

`ifdef SERIAL_FRAME_RX_PARITY_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_DATA = 2'd1, S_PARITY = 2'd2, S_STOP = 2'd3} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_DATA = 2'd1, S_STOP = 2'd3} state_t;
`endif

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [DATA_W-1:0] r_shift;
  logic [DATA_W-1:0] w_shift_nxt;
  logic [DATA_W-1:0] r_data;
  logic              r_valid;
  logic              r_frame_err;
  logic              r_parity_err;
  logic              r_overrun;
  logic              w_stop_sample;
  logic              w_par_bad;
  logic              w_commit;
  logic              w_load;
  logic              w_consume;

`ifdef SERIAL_FRAME_RX_PARITY_EN
  // Running XOR of data bits, then of the parity bit: nonzero at STOP means mismatch.
  logic r_par;
  logic w_par_nxt;
`endif

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_shift_nxt   = r_shift;
    w_stop_sample = 1'b0;
`ifdef SERIAL_FRAME_RX_PARITY_EN
    w_par_nxt     = r_par;
`endif
    if (bus.bit_en) begin
      case (r_state)
        S_IDLE: begin
          if (!bus.serial_in) begin
            w_state_nxt = S_DATA;
            w_cnt_nxt   = '0;
`ifdef SERIAL_FRAME_RX_PARITY_EN
            w_par_nxt   = 1'b0;
`endif
          end
        end
        S_DATA: begin
          if (LSB_FIRST) begin
            w_shift_nxt = {bus.serial_in, r_shift[DATA_W-1:1]};
          end else begin
            w_shift_nxt = {r_shift[DATA_W-2:0], bus.serial_in};
          end
          w_cnt_nxt = r_cnt + 1'b1;
`ifdef SERIAL_FRAME_RX_PARITY_EN
          w_par_nxt = r_par ^ bus.serial_in;
`endif
          if (r_cnt == LAST_BIT) begin
`ifdef SERIAL_FRAME_RX_PARITY_EN
            w_state_nxt = S_PARITY;
`else
            w_state_nxt = S_STOP;
`endif
          end
        end
`ifdef SERIAL_FRAME_RX_PARITY_EN
        S_PARITY: begin
          w_par_nxt   = r_par ^ bus.serial_in;
          w_state_nxt = S_STOP;
        end
`endif
        S_STOP: begin
          w_stop_sample = 1'b1;
          w_state_nxt   = S_IDLE;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

`ifdef SERIAL_FRAME_RX_PARITY_EN
  assign w_par_bad = r_par;
`else
  assign w_par_bad = 1'b0;
`endif

  assign w_commit  = w_stop_sample & bus.serial_in & ~w_par_bad;
  assign w_consume = r_valid & bus.data_ready;
  // A held word blocks a new one unless it is being taken on this same edge.
  assign w_load    = w_commit & (~r_valid | bus.data_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_shift <= '0;
`ifdef SERIAL_FRAME_RX_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_shift <= w_shift_nxt;
`ifdef SERIAL_FRAME_RX_PARITY_EN
      r_par   <= w_par_nxt;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data       <= '0;
      r_valid      <= 1'b0;
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      if (w_load) begin
        r_data  <= r_shift;
        r_valid <= 1'b1;
      end else if (w_consume) begin
        r_valid <= 1'b0;
      end
      r_frame_err  <= w_stop_sample & ~bus.serial_in;
      r_parity_err <= w_stop_sample & w_par_bad;
      r_overrun    <= w_commit & r_valid & ~bus.data_ready;
    end
  end

  assign bus.data_out   = r_data;
  assign bus.data_valid = r_valid;
  assign bus.busy       = (r_state != S_IDLE);
  assign bus.frame_err  = r_frame_err;
  assign bus.parity_err = r_parity_err;
  assign bus.overrun    = r_overrun;
  assign bus.state_dbg  = r_state;
endmodule

// File: tb/tb_serial_frame_rx.sv
// Directed bench for serial_frame_rx: one LSB-first and one MSB-first instance share the same serial stream.
// Builds with or without SERIAL_FRAME_RX_PARITY_EN.
module tb_serial_frame_rx;
  logic clk;
  logic rst;
  logic bit_en;
  logic serial_in;
  logic data_ready;
  logic half;
  int   check_cnt;
  int   err_cnt;

  serial_frame_rx_if #(.DATA_W(8)) if_lsb ();
  serial_frame_rx_if #(.DATA_W(8)) if_msb ();

  assign if_lsb.bit_en     = bit_en;
  assign if_lsb.serial_in  = serial_in;
  assign if_lsb.data_ready = data_ready;
  assign if_msb.bit_en     = bit_en;
  assign if_msb.serial_in  = serial_in;
  assign if_msb.data_ready = data_ready;

  serial_frame_rx #(.DATA_W(8), .LSB_FIRST(1'b1)) u_dut_lsb (.clk(clk), .rst(rst), .bus(if_lsb.slave));
  serial_frame_rx #(.DATA_W(8), .LSB_FIRST(1'b0)) u_dut_msb (.clk(clk), .rst(rst), .bus(if_msb.slave));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] bitrev(input logic [7:0] d);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = d[7-i];
    return r;
  endfunction

  // driver tasks
  task automatic send_bit(input logic b, input logic rdy);
    if (half) begin
      @(negedge clk);
      bit_en     = 1'b0;
      data_ready = 1'b0;
    end
    @(negedge clk);
    bit_en     = 1'b1;
    serial_in  = b;
    data_ready = rdy;
    @(posedge clk);
    #1;
    data_ready = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_flip, input logic rdy_stop);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i], 1'b0);
`ifdef SERIAL_FRAME_RX_PARITY_EN
    send_bit((^d) ^ par_flip, 1'b0);
`else
    if (par_flip) $display("note: parity flip ignored without parity bit");
`endif
    send_bit(stop_b, rdy_stop);
  endtask

  task automatic idle_cycle(input logic rdy);
    @(negedge clk);
    bit_en     = 1'b0;
    data_ready = rdy;
    @(posedge clk);
    #1;
    data_ready = 1'b0;
  endtask

  // scoreboard: expected word and status right after the stop-bit edge
  task automatic chk_frame(input string tag, input logic ev, input logic [7:0] ed,
                           input logic efe, input logic epe, input logic eov);
    chk({tag, ".data_lsb"}, {24'd0, if_lsb.data_out}, {24'd0, ed});
    chk({tag, ".data_msb"}, {24'd0, if_msb.data_out}, {24'd0, bitrev(ed)});
    chk({tag, ".valid"}, {30'd0, if_lsb.data_valid, if_msb.data_valid}, {30'd0, ev, ev});
    chk({tag, ".frame_err"}, {31'd0, if_lsb.frame_err}, {31'd0, efe});
    chk({tag, ".parity_err"}, {31'd0, if_lsb.parity_err}, {31'd0, epe});
    chk({tag, ".overrun"}, {31'd0, if_lsb.overrun}, {31'd0, eov});
    chk({tag, ".busy"}, {30'd0, if_lsb.busy, if_msb.busy}, 32'd0);
  endtask

  initial begin
    check_cnt  = 0;
    err_cnt    = 0;
    half       = 1'b0;
    rst        = 1'b1;
    bit_en     = 1'b0;
    serial_in  = 1'b1;
    data_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_frame("reset", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
    chk_frame("a5", 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
    idle_cycle(1'b1);
    chk("a5.consumed", {31'd0, if_lsb.data_valid}, 32'd0);

    send_frame(8'h01, 1'b1, 1'b0, 1'b0);
    chk_frame("x01", 1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
    idle_cycle(1'b1);

    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    chk_frame("bad_stop", 1'b0, 8'h01, 1'b1, 1'b0, 1'b0);
    send_frame(8'h5A, 1'b1, 1'b0, 1'b0);
    chk_frame("b2b_5a", 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
    idle_cycle(1'b1);

    send_frame(8'h11, 1'b1, 1'b0, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0, 1'b0);
    chk_frame("overrun", 1'b1, 8'h11, 1'b0, 1'b0, 1'b1);
    idle_cycle(1'b0);
    chk("overrun.pulse_end", {31'd0, if_lsb.overrun}, 32'd0);
    chk("overrun.held", {24'd0, if_lsb.data_out}, 32'h11);
    idle_cycle(1'b1);
    chk("overrun.consumed", {31'd0, if_lsb.data_valid}, 32'd0);

    send_frame(8'h11, 1'b1, 1'b0, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0, 1'b1);
    chk_frame("ready_on_commit", 1'b1, 8'h22, 1'b0, 1'b0, 1'b0);

    // async reset mid-DATA with 0x22 still held
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b0, 1'b0);
    chk("mid.busy", {31'd0, if_lsb.busy}, 32'd1);
    #3;
    rst = 1'b1;
    #1;
    chk_frame("async_rst", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    #9;
    rst = 1'b0;
    send_frame(8'hF0, 1'b1, 1'b0, 1'b0);
    chk_frame("after_rst_f0", 1'b1, 8'hF0, 1'b0, 1'b0, 1'b0);
    idle_cycle(1'b1);

    half = 1'b1;
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
    chk_frame("half_a5", 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
    idle_cycle(1'b1);
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    chk_frame("half_bad_stop", 1'b0, 8'hA5, 1'b1, 1'b0, 1'b0);
    idle_cycle(1'b0);
    chk("half_bad_stop.pulse_end", {31'd0, if_lsb.frame_err}, 32'd0);

`ifdef SERIAL_FRAME_RX_PARITY_EN
    half = 1'b0;
    send_frame(8'hC3, 1'b1, 1'b0, 1'b0);
    chk_frame("par_good", 1'b1, 8'hC3, 1'b0, 1'b0, 1'b0);
    idle_cycle(1'b1);
    send_frame(8'hA5, 1'b1, 1'b1, 1'b0);
    chk_frame("par_bad", 1'b0, 8'hC3, 1'b0, 1'b1, 1'b0);
    idle_cycle(1'b0);
    chk("par_bad.pulse_end", {31'd0, if_lsb.parity_err}, 32'd0);
    half = 1'b1;
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
    chk_frame("half_par_good", 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
    idle_cycle(1'b1);
    send_frame(8'hA5, 1'b0, 1'b1, 1'b0);
    chk_frame("half_par_bad_stop", 1'b0, 8'hA5, 1'b1, 1'b1, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", check_cnt, err_cnt);
    $finish;
  end
endmodule
